tag_write_queue: RTL and testbench
==================================

TAG_WRITE_QUEUE -- requirements
Module: tag_write_queue

Interface
REQ-001 Parameters SHALL be (name, default, meaning): QUEUE_DEPTH, 4, request buffer entries; NUM_SETS, 64, sets cleared at init; NUM_WAYS, 8, way_en width; TAG_BITS, 24, tag width.
REQ-002 Clocking SHALL be: one clock; reset is asynchronous and active-high.
REQ-003 Port list SHALL be (name  direction  width  meaning):
- clock  in  1  sole clock.
- reset  in  1  asynchronous active-high reset.
- io_req_valid  in  1  arbitrated tag-write request valid.
- io_req_ready  out  1  request accepted when valid and ready are both high.
- io_req_bits_idx  in  6  set index.
- io_req_bits_way_en  in  8  one-hot or multi-hot way mask.
- io_req_bits_tag  in  24  tag to write.
- io_read_block  in  1  a tag SRAM read is scheduled next cycle, so no write may be issued this cycle.
- io_sram_wen  out  1  registered SRAM write enable.
- io_sram_idx  out  6  registered write set.
- io_sram_way_en  out  8  registered write way mask.
- io_sram_tag  out  24  registered write tag.
- io_init_done  out  1  tag-array clear complete.
- io_count  out  3  current queue occupancy, 0..4.

Function
REQ-010 Block SHALL implement a two-state FSM with states INIT and RUN; reset SHALL force INIT.
REQ-011 In INIT, io_req_ready SHALL be 0.
REQ-012 In INIT, each cycle with io_read_block=0 SHALL issue one clear write: idx = init counter, way_en = 8'hFF, tag = 0. The counter increments after each clear write issues.
REQ-013 In INIT, a cycle with io_read_block=1 SHALL issue nothing and hold the counter.
REQ-014 The FSM SHALL move INIT->RUN on the edge that issues idx 63; io_init_done SHALL be 1 from that edge until the next reset.
REQ-015 In RUN, io_req_ready SHALL equal (count < QUEUE_DEPTH); ready is not raised by a same-cycle dequeue.
REQ-016 The queue SHALL be a circular FIFO with 2-bit read/write pointers that wrap modulo 4. Order SHALL be strictly first-in first-out.
REQ-017 In RUN, the head SHALL be dequeued on any cycle where count>0 and io_read_block=0; its fields SHALL be registered onto io_sram_* with io_sram_wen=1 on the next edge.
REQ-018 io_sram_wen SHALL be 0 in every cycle following an edge where no write was issued; io_sram_idx, io_sram_way_en and io_sram_tag SHALL then hold their last values.
REQ-019 Minimum latency SHALL be two cycles: a request accepted at edge N into an empty queue produces io_sram_wen=1 after edge N+1.
REQ-020 Simultaneous enqueue and dequeue SHALL leave count unchanged; at count=0, the newly enqueued entry SHALL NOT be dequeued in the same cycle.
REQ-021 A request with way_en=0 SHALL be accepted and enqueued, and SHALL be dequeued without asserting io_sram_wen.
REQ-022 io_count SHALL reflect occupancy after the most recent edge.

Reset
REQ-030 Assertion of reset SHALL immediately (asynchronously) set: state=INIT, init counter=0, both pointers=0, count=0, io_sram_wen=0, io_sram_idx=0, io_sram_way_en=0, io_sram_tag=0, io_init_done=0, io_req_ready=0.
REQ-031 Reset during RUN or mid-INIT SHALL discard all queued entries and restart clearing from idx 0.

Structure
REQ-040 QUEUE_DEPTH, NUM_SETS, NUM_WAYS, TAG_BITS, the FSM state encoding and the request record type (idx, way_en, tag) SHALL live in the shared dcache meta package.
REQ-041 The FIFO storage and pointer logic SHALL be one sub-module, tag_write_fifo; the FSM and the output register stage SHALL stay in the top module.

Verification
REQ-050 Release reset with io_read_block=0 -> 64 consecutive writes idx 0..63, way_en=FF, tag=0; io_init_done=1 after the 64th edge; io_req_ready=0 throughout INIT.
REQ-051 During INIT, hold io_read_block=1 for 5 cycles at idx 10 -> no wen for those cycles, clearing resumes at idx 10, io_init_done is delayed by 5 cycles.
REQ-052 In RUN, hold io_read_block=1 and send 5 back-to-back requests -> first 4 accepted, io_count=4, ready=0 on the 5th; release block -> 4 in-order writes on consecutive cycles, then the 5th is accepted.
REQ-053 Single request idx=0x2A, way_en=0x04, tag=0xABCDEF accepted at edge N -> wen=1 with exactly those fields after edge N+1, wen=0 after N+2.
REQ-054 Request with way_en=0 -> accepted, io_count rises then returns to 0, no wen pulse.
REQ-055 Assert reset with 3 entries queued -> io_count=0 and wen=0 immediately; clearing restarts at idx 0 after release, and the queued entries are never written.

Source files
------------

// File: rtl/tag_write_queue_pkg.sv
// Shared dcache tag-meta definitions: sizes, FSM encoding and the tag-write request record.
package tag_write_queue_pkg;

   localparam int unsigned QUEUE_DEPTH = 4;
   localparam int unsigned NUM_SETS    = 64;
   localparam int unsigned NUM_WAYS    = 8;
   localparam int unsigned TAG_BITS    = 24;
   localparam int unsigned IDX_BITS    = $clog2(NUM_SETS);
   localparam int unsigned CNT_BITS    = $clog2(QUEUE_DEPTH + 1);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic [IDX_BITS-1:0] idx;
      logic [NUM_WAYS-1:0] way_en;
      logic [TAG_BITS-1:0] tag;
   } req_t;

endpackage

// File: rtl/tag_write_queue_if.sv
// Tag-write request handshake between the arbiter (master) and the write queue (slave).
interface tag_write_queue_if;
   import tag_write_queue_pkg::*;

   logic                valid;
   logic                ready;
   logic [IDX_BITS-1:0] bits_idx;
   logic [NUM_WAYS-1:0] bits_way_en;
   logic [TAG_BITS-1:0] bits_tag;

   modport master (output valid, output bits_idx, output bits_way_en, output bits_tag,
                   input  ready);
   modport slave  (input  valid, input  bits_idx, input  bits_way_en, input  bits_tag,
                   output ready);
endinterface

// File: rtl/tag_write_queue_fifo.sv
// Circular request FIFO with wrapping read/write pointers and an occupancy counter.
module tag_write_fifo
   import tag_write_queue_pkg::*;
#(
   parameter int unsigned DEPTH = QUEUE_DEPTH,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  req_t             push_data,
   output req_t             head_c,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] count_next_c
);

   req_t             mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Next pointer value, wrapping at the last entry.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign head_c = mem[rd_ptr];

   // Occupancy after this edge; push and pop together leave it unchanged.
   always_comb begin
      count_next_c = count;
      case ({push, pop})
         2'b10:   count_next_c = count + CNT_W'(1);
         2'b01:   count_next_c = count - CNT_W'(1);
         default: count_next_c = count;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count_next_c;
      end
   end

   // Entry storage; contents are meaningless until written, so no reset.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/tag_write_queue.sv
// Tag-array write queue: clears every set after reset, then drains buffered tag writes
// to the SRAM in order whenever no tag read is scheduled.
module tag_write_queue
   import tag_write_queue_pkg::req_t;
   import tag_write_queue_pkg::state_t;
   import tag_write_queue_pkg::ST_INIT;
   import tag_write_queue_pkg::ST_RUN;
   import tag_write_queue_pkg::IDX_BITS;
#(
   parameter int unsigned QUEUE_DEPTH = tag_write_queue_pkg::QUEUE_DEPTH,
   parameter int unsigned NUM_SETS    = tag_write_queue_pkg::NUM_SETS,
   parameter int unsigned NUM_WAYS    = tag_write_queue_pkg::NUM_WAYS,
   parameter int unsigned TAG_BITS    = tag_write_queue_pkg::TAG_BITS,
   localparam int unsigned CNT_W      = $clog2(QUEUE_DEPTH + 1)
) (
   input  logic                clock,
   input  logic                reset,
   tag_write_queue_if.slave    io_req,
   input  logic                io_read_block,
   output logic                io_sram_wen,
   output logic [IDX_BITS-1:0] io_sram_idx,
   output logic [NUM_WAYS-1:0] io_sram_way_en,
   output logic [TAG_BITS-1:0] io_sram_tag,
   output logic                io_init_done,
   output logic [CNT_W-1:0]    io_count
);

   state_t              state;
   state_t              state_next;
   logic [IDX_BITS-1:0] init_cnt;
   logic [IDX_BITS-1:0] init_cnt_next;
   logic                ready;
   logic                ready_next;
   logic                push;
   logic                pop;
   logic                load;
   logic                wen_next;
   req_t                sram_next;
   req_t                push_data;
   req_t                head;
   logic [CNT_W-1:0]    count_next;

   assign io_req.ready = ready;
   assign push         = io_req.valid && ready;

   always_comb begin
      push_data        = '0;
      push_data.idx    = io_req.bits_idx;
      push_data.way_en = io_req.bits_way_en;
      push_data.tag    = io_req.bits_tag;
   end

   tag_write_fifo #(
      .DEPTH (QUEUE_DEPTH)
   ) u_fifo (
      .clock        (clock),
      .reset        (reset),
      .push         (push),
      .pop          (pop),
      .push_data    (push_data),
      .head_c       (head),
      .count        (io_count),
      .count_next_c (count_next)
   );

   // Next state, clear-counter advance, dequeue decision and the next SRAM write.
   always_comb begin
      state_next    = state;
      init_cnt_next = init_cnt;
      pop           = 1'b0;
      load          = 1'b0;
      wen_next      = 1'b0;
      sram_next     = head;
      case (state)
         ST_INIT: begin
            if (!io_read_block) begin
               load             = 1'b1;
               wen_next         = 1'b1;
               sram_next.idx    = init_cnt;
               sram_next.way_en = {NUM_WAYS{1'b1}};
               sram_next.tag    = TAG_BITS'(0);
               init_cnt_next    = init_cnt + IDX_BITS'(1);
               if (init_cnt == IDX_BITS'(NUM_SETS - 1)) state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            // An empty way mask still leaves the queue, it just never reaches the SRAM.
            if ((io_count != '0) && !io_read_block) begin
               pop = 1'b1;
               if (|head.way_en) begin
                  load     = 1'b1;
                  wen_next = 1'b1;
               end
            end
         end
         default: state_next = ST_INIT;
      endcase
      ready_next = (state_next == ST_RUN) && (count_next < CNT_W'(QUEUE_DEPTH));
   end

   // FSM, clear counter and handshake-ready registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= ST_INIT;
         init_cnt     <= '0;
         ready        <= 1'b0;
         io_init_done <= 1'b0;
      end else begin
         state        <= state_next;
         init_cnt     <= init_cnt_next;
         ready        <= ready_next;
         io_init_done <= (state_next == ST_RUN);
      end
   end

   // SRAM write port register stage; fields hold between writes.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         io_sram_wen    <= 1'b0;
         io_sram_idx    <= '0;
         io_sram_way_en <= '0;
         io_sram_tag    <= '0;
      end else begin
         io_sram_wen <= wen_next;
         if (load) begin
            io_sram_idx    <= sram_next.idx;
            io_sram_way_en <= sram_next.way_en;
            io_sram_tag    <= sram_next.tag;
         end
      end
   end

endmodule

// File: tb/tb_tag_write_queue.sv
// Directed bench for tag_write_queue: init clearing, read-block stalls, FIFO ordering,
// full back-pressure, empty way masks and reset while entries are queued.
module tb_tag_write_queue;

   logic        clock;
   logic        reset;
   logic        io_read_block;
   logic        io_sram_wen;
   logic [5:0]  io_sram_idx;
   logic [7:0]  io_sram_way_en;
   logic [23:0] io_sram_tag;
   logic        io_init_done;
   logic [2:0]  io_count;

   int errors = 0;
   int checks = 0;

   tag_write_queue_if req_if ();

   tag_write_queue dut (
      .clock          (clock),
      .reset          (reset),
      .io_req         (req_if),
      .io_read_block  (io_read_block),
      .io_sram_wen    (io_sram_wen),
      .io_sram_idx    (io_sram_idx),
      .io_sram_way_en (io_sram_way_en),
      .io_sram_tag    (io_sram_tag),
      .io_init_done   (io_init_done),
      .io_count       (io_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle before sampling.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_req(input logic v, input logic [5:0] idx, input logic [7:0] way,
                            input logic [23:0] tag);
      req_if.valid       = v;
      req_if.bits_idx    = idx;
      req_if.bits_way_en = way;
      req_if.bits_tag    = tag;
   endtask

   task automatic chk_write(input string tag, input logic [5:0] idx, input logic [7:0] way,
                            input logic [23:0] t);
      chk({tag, ".wen"}, 32'(io_sram_wen), 32'd1);
      chk({tag, ".idx"}, 32'(io_sram_idx), 32'(idx));
      chk({tag, ".way"}, 32'(io_sram_way_en), 32'(way));
      chk({tag, ".tag"}, 32'(io_sram_tag), 32'(t));
   endtask

   initial begin
      reset         = 1'b1;
      io_read_block = 1'b0;
      drive_req(1'b0, 6'h0, 8'h0, 24'h0);
      #1;
      chk("rst.wen", 32'(io_sram_wen), 32'd0);
      chk("rst.idx", 32'(io_sram_idx), 32'd0);
      chk("rst.done", 32'(io_init_done), 32'd0);
      chk("rst.ready", 32'(req_if.ready), 32'd0);
      chk("rst.count", 32'(io_count), 32'd0);
      step();
      step();
      reset = 1'b0;

      // Full clear pass: one write per edge, idx 0..63.
      for (int i = 0; i < 64; i++) begin
         step();
         chk_write($sformatf("init%0d", i), 6'(i), 8'hFF, 24'h0);
         chk($sformatf("init%0d.done", i), 32'(io_init_done), 32'(i == 63));
         chk($sformatf("init%0d.ready", i), 32'(req_if.ready), 32'(i == 63));
      end
      step();
      chk("idle.wen", 32'(io_sram_wen), 32'd0);
      chk("idle.idx_hold", 32'(io_sram_idx), 32'd63);

      // Single request: accepted at edge N, written after N+1, idle after N+2.
      drive_req(1'b1, 6'h2A, 8'h04, 24'hABCDEF);
      step();
      chk("one.count_acc", 32'(io_count), 32'd1);
      chk("one.wen_acc", 32'(io_sram_wen), 32'd0);
      drive_req(1'b0, 6'h0, 8'h0, 24'h0);
      step();
      chk_write("one.wr", 6'h2A, 8'h04, 24'hABCDEF);
      chk("one.count_wr", 32'(io_count), 32'd0);
      step();
      chk("one.wen_after", 32'(io_sram_wen), 32'd0);
      chk("one.idx_hold", 32'(io_sram_idx), 32'h2A);

      // Blocked fill: four accepted, the fifth sees ready low.
      io_read_block = 1'b1;
      for (int k = 0; k < 5; k++) begin
         drive_req(1'b1, 6'(k + 1), 8'(1 << k), 24'(256 + k));
         chk($sformatf("fill%0d.ready", k), 32'(req_if.ready), 32'(k < 4));
         step();
         chk($sformatf("fill%0d.count", k), 32'(io_count), 32'((k < 4) ? k + 1 : 4));
         chk($sformatf("fill%0d.wen", k), 32'(io_sram_wen), 32'd0);
      end

      // Unblock: in-order drain; the held fifth request enters once a slot frees.
      io_read_block = 1'b0;
      step();
      chk_write("drain0", 6'd1, 8'h01, 24'd256);
      chk("drain0.count", 32'(io_count), 32'd3);
      chk("drain0.ready", 32'(req_if.ready), 32'd1);
      step();
      drive_req(1'b0, 6'h0, 8'h0, 24'h0);
      chk_write("drain1", 6'd2, 8'h02, 24'd257);
      chk("drain1.count", 32'(io_count), 32'd3);
      step();
      chk_write("drain2", 6'd3, 8'h04, 24'd258);
      chk("drain2.count", 32'(io_count), 32'd2);
      step();
      chk_write("drain3", 6'd4, 8'h08, 24'd259);
      chk("drain3.count", 32'(io_count), 32'd1);
      step();
      chk_write("drain4", 6'd5, 8'h10, 24'd260);
      chk("drain4.count", 32'(io_count), 32'd0);
      step();
      chk("drain.end_wen", 32'(io_sram_wen), 32'd0);

      // Empty way mask: enqueued and dequeued, never written.
      drive_req(1'b1, 6'h11, 8'h00, 24'h000001);
      step();
      chk("way0.count_up", 32'(io_count), 32'd1);
      chk("way0.wen_acc", 32'(io_sram_wen), 32'd0);
      drive_req(1'b0, 6'h0, 8'h0, 24'h0);
      step();
      chk("way0.count_down", 32'(io_count), 32'd0);
      chk("way0.wen_deq", 32'(io_sram_wen), 32'd0);
      chk("way0.idx_hold", 32'(io_sram_idx), 32'd5);
      step();
      chk("way0.wen_after", 32'(io_sram_wen), 32'd0);

      // Queue three entries, then reset mid-cycle.
      io_read_block = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive_req(1'b1, 6'(8'h30 + k), 8'h01, 24'h000777);
         step();
      end
      drive_req(1'b0, 6'h0, 8'h0, 24'h0);
      chk("q3.count", 32'(io_count), 32'd3);
      reset = 1'b1;
      #1;
      chk("arst.count", 32'(io_count), 32'd0);
      chk("arst.wen", 32'(io_sram_wen), 32'd0);
      chk("arst.idx", 32'(io_sram_idx), 32'd0);
      chk("arst.done", 32'(io_init_done), 32'd0);
      chk("arst.ready", 32'(req_if.ready), 32'd0);
      step();
      reset         = 1'b0;
      io_read_block = 1'b0;

      // Clearing restarts at 0 and stalls five cycles at idx 10.
      for (int i = 0; i < 10; i++) begin
         step();
         chk_write($sformatf("reinit%0d", i), 6'(i), 8'hFF, 24'h0);
      end
      io_read_block = 1'b1;
      for (int s = 0; s < 5; s++) begin
         step();
         chk($sformatf("stall%0d.wen", s), 32'(io_sram_wen), 32'd0);
         chk($sformatf("stall%0d.idx", s), 32'(io_sram_idx), 32'd9);
         chk($sformatf("stall%0d.ready", s), 32'(req_if.ready), 32'd0);
      end
      io_read_block = 1'b0;
      for (int i = 10; i < 64; i++) begin
         step();
         chk_write($sformatf("reinit%0d", i), 6'(i), 8'hFF, 24'h0);
         chk($sformatf("reinit%0d.done", i), 32'(io_init_done), 32'(i == 63));
      end

      // The discarded entries never show up.
      for (int s = 0; s < 3; s++) begin
         step();
         chk($sformatf("post%0d.wen", s), 32'(io_sram_wen), 32'd0);
         chk($sformatf("post%0d.count", s), 32'(io_count), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
